// File: rtl/ddr3_rw_arbiter.sv
// Shares one DDR3 MIG user port between a write-burst and a read-burst engine.
// Build option: define ARB_RD_PRIORITY_EN so reads always win ties; otherwise ties alternate round-robin.
module ddr3_rw_arbiter #(
  parameter int ADDR_W    = 29,
  parameter int ADDR_STEP = 8
) (
  input  logic              ui_clk,
  input  logic              ui_clk_sync_rst,
  input  logic              init_calib_complete,
  input  logic              wr_req,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        wr_bust_len,
  input  logic [7:0]        rd_bust_len,
  output logic              wr_grant,
  output logic              rd_grant,
  output logic              wr_done,
  output logic              rd_done,
  output logic              wrfifo_rden,
  input  logic              app_rdy,
  input  logic              app_wdf_rdy,
  output logic              app_en,
  output logic              app_wdf_wren,
  output logic              app_wdf_end,
  output logic [2:0]        app_cmd,
  output logic [ADDR_W-1:0] app_addr
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        remain_q, remain_d;
  logic              is_rd_q, is_rd_d;
  logic              last_rd_q, last_rd_d;
  logic              wr_grant_q, wr_grant_d;
  logic              rd_grant_q, rd_grant_d;
  logic              wr_done_q, wr_done_d;
  logic              rd_done_q, rd_done_d;

  logic              wr_beat;
  logic              rd_beat;
  logic              pick_rd;
  logic [7:0]        sel_len;

  always_comb begin
    wr_beat = (state_q == WRITE) && app_rdy && app_wdf_rdy;
    rd_beat = (state_q == READ) && app_rdy;
`ifdef ARB_RD_PRIORITY_EN
    pick_rd = rd_req;
`else
    pick_rd = rd_req && (!wr_req || !last_rd_q);
`endif
    sel_len = pick_rd ? rd_bust_len : wr_bust_len;

    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    is_rd_d    = is_rd_q;
    last_rd_d  = last_rd_q;
    wr_grant_d = wr_grant_q;
    rd_grant_d = rd_grant_q;
    wr_done_d  = 1'b0;
    rd_done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (init_calib_complete && (wr_req || rd_req)) begin
          is_rd_d  = pick_rd;
          addr_d   = pick_rd ? rd_addr : wr_addr;
          remain_d = sel_len;
          // Zero-length bursts skip straight to DONE so the engine still sees its done pulse.
          if (sel_len == 8'd0) begin
            state_d   = DONE;
            wr_done_d = !pick_rd;
            rd_done_d = pick_rd;
          end else begin
            state_d    = pick_rd ? READ : WRITE;
            wr_grant_d = !pick_rd;
            rd_grant_d = pick_rd;
          end
        end
      end
      WRITE, READ: begin
        if (wr_beat || rd_beat) begin
          addr_d   = addr_q + ADDR_W'(ADDR_STEP);
          remain_d = remain_q - 8'd1;
          if (remain_q == 8'd1) begin
            state_d    = DONE;
            wr_grant_d = 1'b0;
            rd_grant_d = 1'b0;
            wr_done_d  = !is_rd_q;
            rd_done_d  = is_rd_q;
          end
        end
      end
      DONE: begin
        state_d   = IDLE;
        last_rd_d = is_rd_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ui_clk) begin
    if (ui_clk_sync_rst) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      is_rd_q    <= 1'b0;
      last_rd_q  <= 1'b0;
      wr_grant_q <= 1'b0;
      rd_grant_q <= 1'b0;
      wr_done_q  <= 1'b0;
      rd_done_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      is_rd_q    <= is_rd_d;
      last_rd_q  <= last_rd_d;
      wr_grant_q <= wr_grant_d;
      rd_grant_q <= rd_grant_d;
      wr_done_q  <= wr_done_d;
      rd_done_q  <= rd_done_d;
    end
  end

  // Beat strobes must follow the ready handshake in the same cycle, so they are not registered.
  assign app_en       = wr_beat || rd_beat;
  assign app_wdf_wren = wr_beat;
  assign app_wdf_end  = wr_beat;
  assign wrfifo_rden  = wr_beat;
  assign app_cmd      = (state_q == READ) ? 3'b001 : 3'b000;
  assign app_addr     = addr_q;
  assign wr_grant     = wr_grant_q;
  assign rd_grant     = rd_grant_q;
  assign wr_done      = wr_done_q;
  assign rd_done      = rd_done_q;

endmodule

// File: tb/tb_ddr3_rw_arbiter.sv
// Self-checking bench for ddr3_rw_arbiter: directed scenarios plus random traffic
// checked every cycle against a burst-level reference model.
module tb_ddr3_rw_arbiter;

  localparam int ADDR_W    = 29;
  localparam int ADDR_STEP = 8;

  logic              ui_clk = 1'b0;
  logic              ui_clk_sync_rst;
  logic              init_calib_complete;
  logic              wr_req, rd_req;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [7:0]        wr_bust_len, rd_bust_len;
  logic              wr_grant, rd_grant, wr_done, rd_done, wrfifo_rden;
  logic              app_rdy, app_wdf_rdy;
  logic              app_en, app_wdf_wren, app_wdf_end;
  logic [2:0]        app_cmd;
  logic [ADDR_W-1:0] app_addr;

  always #5 ui_clk = ~ui_clk;

  ddr3_rw_arbiter #(.ADDR_W(ADDR_W), .ADDR_STEP(ADDR_STEP)) dut (
    .ui_clk(ui_clk), .ui_clk_sync_rst(ui_clk_sync_rst),
    .init_calib_complete(init_calib_complete),
    .wr_req(wr_req), .rd_req(rd_req),
    .wr_addr(wr_addr), .rd_addr(rd_addr),
    .wr_bust_len(wr_bust_len), .rd_bust_len(rd_bust_len),
    .wr_grant(wr_grant), .rd_grant(rd_grant),
    .wr_done(wr_done), .rd_done(rd_done), .wrfifo_rden(wrfifo_rden),
    .app_rdy(app_rdy), .app_wdf_rdy(app_wdf_rdy),
    .app_en(app_en), .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end),
    .app_cmd(app_cmd), .app_addr(app_addr)
  );

  // Staged inputs, copied onto the DUT at the falling edge of each cycle.
  logic              s_rst, s_calib, s_wr_req, s_rd_req, s_app_rdy, s_app_wdf_rdy;
  logic [ADDR_W-1:0] s_wr_addr, s_rd_addr;
  logic [7:0]        s_wr_len, s_rd_len;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model: phase 0 = idle, 1 = burst in flight, 2 = done cycle.
  int                m_phase   = 0;
  bit                m_rd      = 1'b0;
  bit                m_last_rd = 1'b0;
  bit                m_rst_chk = 1'b1;
  logic [ADDR_W-1:0] m_q[$];

  // Observations gathered from DUT outputs for directed checks and the random requesters.
  logic [ADDR_W-1:0] obs_addr[$];
  int cnt_rden, cnt_wr_done, cnt_rd_done, g_code, grant_cyc, last_en_cyc, done_cyc;
  bit saw_wr_done, saw_rd_done, saw_wr_grant, saw_rd_grant, prev_wr_grant, prev_rd_grant;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
    end
  endtask

  // One clock cycle: drive, check against the model, record, then advance the model over the edge.
  task automatic applyStimulus();
    bit exp_beat;
    bit take_rd;
    logic [ADDR_W-1:0] start;
    int len;
    @(negedge ui_clk);
    ui_clk_sync_rst     = s_rst;
    init_calib_complete = s_calib;
    wr_req = s_wr_req;  rd_req = s_rd_req;
    wr_addr = s_wr_addr; rd_addr = s_rd_addr;
    wr_bust_len = s_wr_len; rd_bust_len = s_rd_len;
    app_rdy = s_app_rdy; app_wdf_rdy = s_app_wdf_rdy;
    #1;
    exp_beat = (m_phase == 1) && s_app_rdy && (m_rd || s_app_wdf_rdy);
    checkOutput("wr_grant", wr_grant, (m_phase == 1) && !m_rd);
    checkOutput("rd_grant", rd_grant, (m_phase == 1) && m_rd);
    checkOutput("wr_done", wr_done, (m_phase == 2) && !m_rd);
    checkOutput("rd_done", rd_done, (m_phase == 2) && m_rd);
    checkOutput("app_en", app_en, exp_beat);
    checkOutput("app_wdf_wren", app_wdf_wren, exp_beat && !m_rd);
    checkOutput("app_wdf_end", app_wdf_end, exp_beat && !m_rd);
    checkOutput("wrfifo_rden", wrfifo_rden, exp_beat && !m_rd);
    if (exp_beat) begin
      checkOutput("app_cmd", app_cmd, m_rd ? 64'd1 : 64'd0);
      checkOutput("app_addr", app_addr, m_q[0]);
    end
    if (m_rst_chk) begin
      checkOutput("app_addr_after_reset", app_addr, 0);
      checkOutput("app_cmd_after_reset", app_cmd, 0);
    end

    if (app_en) begin
      obs_addr.push_back(app_addr);
      last_en_cyc = cyc;
    end
    if (wrfifo_rden) cnt_rden++;
    if (wr_done) begin cnt_wr_done++; done_cyc = cyc; end
    if (rd_done) begin cnt_rd_done++; done_cyc = cyc; end
    if (wr_grant && !prev_wr_grant) begin g_code = g_code * 4 + 1; grant_cyc = cyc; end
    if (rd_grant && !prev_rd_grant) begin g_code = g_code * 4 + 2; grant_cyc = cyc; end
    prev_wr_grant = wr_grant; prev_rd_grant = rd_grant;
    saw_wr_done = wr_done; saw_rd_done = rd_done;
    saw_wr_grant = wr_grant; saw_rd_grant = rd_grant;

    if (s_rst) begin
      m_phase = 0; m_last_rd = 1'b0; m_rst_chk = 1'b1;
      m_q.delete();
    end else if (m_phase == 1) begin
      if (exp_beat) begin
        void'(m_q.pop_front());
        if (m_q.size() == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
      m_phase = 0;
      m_last_rd = m_rd;
    end else if (s_calib && (s_wr_req || s_rd_req)) begin
`ifdef ARB_RD_PRIORITY_EN
      take_rd = s_rd_req;
`else
      take_rd = (s_wr_req && s_rd_req) ? !m_last_rd : s_rd_req;
`endif
      m_rd  = take_rd;
      start = take_rd ? s_rd_addr : s_wr_addr;
      len   = take_rd ? int'(s_rd_len) : int'(s_wr_len);
      for (int i = 0; i < len; i++) m_q.push_back(start + ADDR_W'(i * ADDR_STEP));
      m_phase   = (len == 0) ? 2 : 1;
      m_rst_chk = 1'b0;
    end
    cyc++;
  endtask

  task automatic runUntilDone(input bit want_rd, input int max_cycles, input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles && !seen; i++) begin
      applyStimulus();
      seen = want_rd ? saw_rd_done : saw_wr_done;
    end
    checkOutput(tag, seen, 1);
  endtask

  function automatic logic [ADDR_W-1:0] randAddr();
    logic [ADDR_W-1:0] a;
    if ($urandom_range(0, 3) == 0) begin
      a = '1;
      a = a - ADDR_W'(7 + 8 * $urandom_range(0, 3));
    end else begin
      a = ADDR_W'($urandom);
      a[2:0] = 3'b000;
    end
    return a;
  endfunction

  task automatic clearObs();
    obs_addr.delete();
    cnt_rden = 0; cnt_wr_done = 0; cnt_rd_done = 0; g_code = 0;
  endtask

  // Directed scenarios first, then random traffic, then a drain period.
  initial begin
    int c0;
    logic [ADDR_W-1:0] exp_a;
    ui_clk_sync_rst = 1'b1; init_calib_complete = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;
    wr_bust_len = '0; rd_bust_len = '0; app_rdy = 1'b0; app_wdf_rdy = 1'b0;
    s_rst = 1'b0; s_calib = 1'b0; s_wr_req = 1'b0; s_rd_req = 1'b0;
    s_wr_addr = '0; s_rd_addr = '0; s_wr_len = '0; s_rd_len = '0;
    s_app_rdy = 1'b1; s_app_wdf_rdy = 1'b1;
    prev_wr_grant = 1'b0; prev_rd_grant = 1'b0;
    clearObs();
    repeat (2) @(posedge ui_clk);

    // Calibration pending: request must be ignored, then granted one cycle after calibration.
    s_wr_req = 1'b1; s_wr_addr = 29'h40; s_wr_len = 8'd1;
    repeat (20) applyStimulus();
    checkOutput("calib_no_grant", g_code, 0);
    checkOutput("calib_no_app_en", obs_addr.size(), 0);
    s_calib = 1'b1;
    c0 = cyc;
    grant_cyc = -1;
    for (int i = 0; i < 5 && grant_cyc < 0; i++) applyStimulus();
    checkOutput("calib_grant_delay", grant_cyc - c0, 1);
    runUntilDone(1'b0, 10, "calib_burst_done");
    s_wr_req = 1'b0;
    applyStimulus();

    // Single 4-beat write.
    clearObs();
    s_wr_req = 1'b1; s_wr_addr = 29'h100; s_wr_len = 8'd4;
    runUntilDone(1'b0, 20, "wr4_done");
    s_wr_req = 1'b0;
    checkOutput("wr4_rden_count", cnt_rden, 4);
    checkOutput("wr4_beats", obs_addr.size(), 4);
    exp_a = 29'h100;
    foreach (obs_addr[i]) begin
      checkOutput("wr4_addr", obs_addr[i], exp_a);
      exp_a = exp_a + 29'h8;
    end
    checkOutput("wr4_done_gap", done_cyc - last_en_cyc, 1);
    applyStimulus();

    // Read across the address wrap with app_rdy toggling.
    clearObs();
    s_rd_req = 1'b1; s_rd_addr = 29'h1FFFFFF0; s_rd_len = 8'd3;
    for (int i = 0; i < 30 && cnt_rd_done == 0; i++) begin
      s_app_rdy = i[0];
      applyStimulus();
    end
    s_rd_req = 1'b0; s_app_rdy = 1'b1;
    checkOutput("rd3_done_count", cnt_rd_done, 1);
    checkOutput("rd3_beats", obs_addr.size(), 3);
    if (obs_addr.size() == 3) begin
      checkOutput("rd3_addr0", obs_addr[0], 29'h1FFFFFF0);
      checkOutput("rd3_addr1", obs_addr[1], 29'h1FFFFFF8);
      checkOutput("rd3_addr2", obs_addr[2], 29'h0);
    end
    applyStimulus();

    // Both requesters held for three bursts; last served was a read.
    clearObs();
    s_wr_req = 1'b1; s_rd_req = 1'b1; s_wr_len = 8'd2; s_rd_len = 8'd2;
    s_wr_addr = 29'h1000; s_rd_addr = 29'h3000;
    for (int i = 0; i < 40 && (cnt_wr_done + cnt_rd_done) < 3; i++) applyStimulus();
    s_wr_req = 1'b0; s_rd_req = 1'b0;
`ifdef ARB_RD_PRIORITY_EN
    checkOutput("grant_order_RRR", g_code, 42);
`else
    checkOutput("grant_order_WRW", g_code, 25);
`endif
    applyStimulus();

    // Zero-length read: done pulse, no commands.
    clearObs();
    s_rd_req = 1'b1; s_rd_len = 8'd0;
    runUntilDone(1'b1, 6, "rd0_done");
    s_rd_req = 1'b0;
    applyStimulus();
    checkOutput("rd0_done_count", cnt_rd_done, 1);
    checkOutput("rd0_no_app_en", obs_addr.size(), 0);

    // Reset after beat 2 of an 8-beat write.
    clearObs();
    s_wr_req = 1'b1; s_wr_addr = 29'h800; s_wr_len = 8'd8;
    for (int i = 0; i < 10 && obs_addr.size() < 2; i++) applyStimulus();
    s_app_rdy = 1'b0; s_rst = 1'b1;
    applyStimulus();
    s_rst = 1'b0; s_wr_req = 1'b0; s_app_rdy = 1'b1;
    repeat (5) applyStimulus();
    checkOutput("rst_no_wr_done", cnt_wr_done, 0);
    checkOutput("rst_beats_before", obs_addr.size(), 2);
    clearObs();
    s_wr_req = 1'b1; s_wr_addr = 29'h2000; s_wr_len = 8'd2;
    runUntilDone(1'b0, 10, "post_rst_done");
    s_wr_req = 1'b0;
    if (obs_addr.size() > 0) checkOutput("post_rst_start", obs_addr[0], 29'h2000);
    applyStimulus();

    // Random traffic with random handshakes, calibration drops and resets.
    for (int i = 0; i < 2500; i++) begin
      if (s_wr_req) begin
        if (saw_wr_done || (saw_wr_grant && $urandom_range(0, 15) == 0)) s_wr_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        s_wr_req = 1'b1; s_wr_addr = randAddr(); s_wr_len = 8'($urandom_range(0, 6));
      end
      if (s_rd_req) begin
        if (saw_rd_done || (saw_rd_grant && $urandom_range(0, 15) == 0)) s_rd_req = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        s_rd_req = 1'b1; s_rd_addr = randAddr(); s_rd_len = 8'($urandom_range(0, 6));
      end
      s_app_rdy     = ($urandom_range(0, 3) != 0);
      s_app_wdf_rdy = ($urandom_range(0, 3) != 0);
      s_calib       = ($urandom_range(0, 19) != 0);
      s_rst         = ($urandom_range(0, 299) == 0);
      applyStimulus();
    end

    s_rst = 1'b0; s_calib = 1'b1; s_wr_req = 1'b0; s_rd_req = 1'b0;
    s_app_rdy = 1'b1; s_app_wdf_rdy = 1'b1;
    repeat (30) applyStimulus();
    checkOutput("drain_idle_wr_grant", wr_grant, 0);
    checkOutput("drain_idle_rd_grant", rd_grant, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
